// File: rtl/ram_dp_clr.sv
// Simple-dual-port synchronous RAM with registered read, hardware clear
// sequencer and out-of-range access trapping.
module ram_dp_clr #(
    parameter int data_width = 8,
    parameter int addr_width = 5,
    parameter int depth      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic                  re,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata,
    output logic                  rvalid,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    // One extra bit so depth == 2**addr_width is representable
    localparam logic [addr_width:0]   depth_w = (addr_width + 1)'(depth);
    localparam logic [addr_width-1:0] last    = addr_width'(depth - 1);

    state_t                state;
    logic [addr_width-1:0] cnt;
    logic [data_width-1:0] mem [depth];

    logic                  access;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  wr_hit;
    logic                  mem_we;
    logic [addr_width-1:0] mem_addr;
    logic [data_width-1:0] mem_data;

    assign access = (state == IDLE) && !clr;
    assign wr_ok  = {1'b0, waddr} < depth_w;
    assign rd_ok  = {1'b0, raddr} < depth_w;
    assign wr_hit = we && wr_ok && (waddr == raddr);

    // Single memory write port shared by the clear sequencer and user writes
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = cnt;
        mem_data = '0;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (access && we && wr_ok) begin
            mem_we   = 1'b1;
            mem_addr = waddr;
            mem_data = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= CLEAR;
            cnt    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            busy   <= 1'b1;
            err    <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            unique case (state)
                CLEAR: begin
                    if (clr) begin
                        cnt <= '0;
                    end else if (cnt == last) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + addr_width'(1);
                    end
                end
                IDLE: begin
                    if (clr) begin
                        cnt   <= '0;
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end else begin
                        err <= (we && !wr_ok) || (re && !rd_ok);
                        if (re) begin
                            rvalid <= 1'b1;
                            if (!rd_ok) begin
                                rdata <= '0;
                            end else if (wr_hit) begin
                                rdata <= wdata;
                            end else begin
                                rdata <= mem[raddr];
                            end
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Randomised self-checking bench: a full-size and a depth-20 instance share
// stimulus and are compared against a countdown/array reference model.
module tb_ram_dp_clr;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       we;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic       re;
    logic [4:0] raddr;

    logic [7:0] rdata0;
    logic       rvalid0;
    logic       busy0;
    logic       err0;
    logic [7:0] rdata1;
    logic       rvalid1;
    logic       busy1;
    logic       err1;

    int n_chk = 0;
    int n_err = 0;

    int         dep    [2];
    logic [7:0] mm     [2][32];
    logic [7:0] e_rd   [2];
    bit         e_rv   [2];
    bit         e_err  [2];
    int         left   [2];

    ram_dp_clr #(.data_width(8), .addr_width(5), .depth(32)) u_dut32 (
        .clk(clk), .rst(rst), .clr(clr),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr),
        .rdata(rdata0), .rvalid(rvalid0), .busy(busy0), .err(err0)
    );

    ram_dp_clr #(.data_width(8), .addr_width(5), .depth(20)) u_dut20 (
        .clk(clk), .rst(rst), .clr(clr),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr),
        .rdata(rdata1), .rvalid(rvalid1), .busy(busy1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("busy32",   32'(busy0),   32'(left[0] > 0));
        check("rvalid32", 32'(rvalid0), 32'(e_rv[0]));
        check("err32",    32'(err0),    32'(e_err[0]));
        check("rdata32",  32'(rdata0),  32'(e_rd[0]));
        check("busy20",   32'(busy1),   32'(left[1] > 0));
        check("rvalid20", 32'(rvalid1), 32'(e_rv[1]));
        check("err20",    32'(err1),    32'(e_err[1]));
        check("rdata20",  32'(rdata1),  32'(e_rd[1]));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            left[k]  = dep[k];
            e_rd[k]  = 8'h00;
            e_rv[k]  = 1'b0;
            e_err[k] = 1'b0;
            for (int a = 0; a < 32; a++) mm[k][a] = 8'h00;
        end
    endtask

    // Effect of one rising edge on each instance's observable behaviour
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            e_rv[k]  = 1'b0;
            e_err[k] = 1'b0;
            if (left[k] > 0) begin
                left[k] = clr ? dep[k] : left[k] - 1;
            end else if (clr) begin
                left[k] = dep[k];
                for (int a = 0; a < 32; a++) mm[k][a] = 8'h00;
            end else begin
                e_err[k] = (we && int'(waddr) >= dep[k]) ||
                           (re && int'(raddr) >= dep[k]);
                if (we && int'(waddr) < dep[k]) mm[k][waddr] = wdata;
                if (re) begin
                    e_rv[k] = 1'b1;
                    e_rd[k] = (int'(raddr) < dep[k]) ? mm[k][raddr] : 8'h00;
                end
            end
        end
    endtask

    task automatic step(input logic c, input logic w, input logic [4:0] wa,
                        input logic [7:0] wd, input logic r,
                        input logic [4:0] ra);
        clr   = c;
        we    = w;
        waddr = wa;
        wdata = wd;
        re    = r;
        raddr = ra;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
    endtask

    task automatic apply_reset();
        clr   = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        waddr = '0;
        raddr = '0;
        wdata = '0;
        rst   = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        dep[0] = 32;
        dep[1] = 20;
        apply_reset();

        // Clear after reset, then every address reads zero
        idle(33);
        for (int a = 0; a < 32; a++) step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'(a));
        idle(1);

        // Basic write then read, including the top address
        step(1'b0, 1'b1, 5'd3,  8'hA5, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd31, 8'h3C, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd3);
        step(1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd31);
        idle(1);

        // Same-address bypass and independent ports
        step(1'b0, 1'b1, 5'd8, 8'h11, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'd7, 8'h5A, 1'b1, 5'd7);
        step(1'b0, 1'b1, 5'd7, 8'h5A, 1'b1, 5'd8);
        step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd7);

        // Out-of-range accesses on the depth-20 instance
        step(1'b0, 1'b1, 5'd25, 8'hFF, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd25);
        step(1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd19);
        step(1'b0, 1'b1, 5'd25, 8'h77, 1'b1, 5'd30);
        step(1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd25);
        idle(1);

        // Randomised traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 8'($urandom),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        idle(34);

        // Fill, clear with traffic during busy, then read back zeros
        for (int a = 0; a < 32; a++) step(1'b0, 1'b1, 5'(a), 8'hC3, 1'b0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd5);
        step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 5'($urandom_range(0, 31)), 8'($urandom),
                 1'b1, 5'($urandom_range(0, 31)));
        end
        for (int a = 0; a < 32; a++) step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'(a));

        // Reset in the middle of a clear sequence
        step(1'b0, 1'b1, 5'd4, 8'h9E, 1'b1, 5'd4);
        step(1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
        idle(10);
        apply_reset();
        idle(33);
        for (int a = 0; a < 32; a++) step(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'(a));
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ram_dp_clr.md
# ram_dp_clr

Parametrised simple-dual-port synchronous RAM, the next-generation storage block for the datapath. It provides one write port and one independent read port, usable in the same cycle, with a registered read and a `rvalid` qualifier. A hardware clear sequencer zeroes every location after reset or on request. Out-of-range accesses are trapped and flagged.

## Interface
- `data_width`, 8, word width in bits (≥1)
- `addr_width`, 5, address width in bits (≥1)
- `depth`, 32, number of words; 1 ≤ depth ≤ 2^addr_width
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `clr` input 1: synchronous clear request; one-cycle pulse is sufficient.
- `we` input 1: write enable.
- `waddr` input addr_width: write address.
- `wdata` input data_width: write data.
- `re` input 1: read enable.
- `raddr` input addr_width: read address.
- `rdata` output data_width: registered read data.
- `rvalid` output 1: `rdata` updated this cycle by an accepted read.
- `busy` output 1: clear in progress; accesses are not accepted.
- `err` output 1: one-cycle pulse on an out-of-range access.

## Operation
- FSM states: CLEAR, IDLE. A clear counter `cnt` is 0..depth-1.
- Reset (`rst`=1, asynchronous):
  - State is CLEAR and `cnt`=0.
  - `rdata`=0, `rvalid`=0, `busy`=1, `err`=0.
  - Memory contents are not reset directly; the CLEAR sequence zeroes them.
- CLEAR:
  - Each edge writes memory[cnt]←0 and increments `cnt`.
  - The edge that writes `cnt`=depth-1 moves to IDLE and drops `busy`.
  - `we`/`re` are ignored (dropped, not queued). `rvalid`=0 and `err`=0.
  - `clr` asserted in CLEAR restarts the sequence with `cnt`=0.
- IDLE:
  - `clr`=1: go to CLEAR, `cnt`=0, `busy`=1 from the next cycle. Any `we`/`re` in that same cycle are dropped.
  - Write: `we`=1 and `waddr`<depth → memory[waddr]←wdata.
  - Read: `re`=1 and `raddr`<depth → rdata←memory[raddr], `rvalid`=1.
  - Read and write to the same address in the same cycle: write-first bypass, so `rdata` gets `wdata`.
  - Read and write to different addresses proceed independently.
  - Out of range, `waddr`≥depth with `we`: write discarded, `err`=1.
  - Out of range, `raddr`≥depth with `re`: `rdata`←0, `rvalid`=1, `err`=1.
  - Both ports out of range in one cycle produce a single `err` pulse.
- No accepted read: `rdata` holds its previous value and `rvalid`=0.
- Range checks compare against `depth`, not 2^addr_width. When depth = 2^addr_width, `err` can never assert.

## Timing
- Read latency is 1 cycle. A read sampled at edge N gives `rdata`/`rvalid` valid after edge N, held until edge N+1.
- A write sampled at edge N is visible to a different-address read sampled at edge N+1. The same-address case is covered by the bypass.
- `rvalid`, `err` and `busy` are registered. No combinational path runs from inputs to outputs.
- After `rst` deasserts, `busy` stays 1 for exactly `depth` rising edges. The first access is accepted at edge depth+1.
- After `clr` is sampled in IDLE at edge N, `busy`=1 from edge N through edge N+depth. The first access is accepted at edge N+depth+1.
- `rst` asserted mid-CLEAR or mid-access: outputs go to reset values immediately, and the sequence restarts from `cnt`=0 after deassertion.

## Test plan
- Reset then idle, defaults: release `rst` → `busy`=1 for 32 cycles, then 0. Reads of all 32 addresses return 0x00 with `rvalid`=1 one cycle later.
- Write/read: write 0xA5@3 and 0x3C@31, then read 3 and 31 → `rdata`=0xA5 then 0x3C, each with one-cycle latency. `rvalid` pulses once per read.
- Simultaneous access: `we`=1 waddr=7 wdata=0x5A with `re`=1 raddr=7 in the same cycle → `rdata`=0x5A next cycle.
  - Repeat with raddr=8 (holding 0x11) → `rdata`=0x11, and a later read of 7 returns 0x5A.
- Out of range with depth=20, addr_width=5:
  - write 0xFF@25 → `err`=1 for one cycle and memory unchanged.
  - read @25 → `rdata`=0, `rvalid`=1, `err`=1.
  - A subsequent read @19 has `err`=0.
- Clear: fill all locations with 0xC3, pulse `clr` → `busy`=1 for 32 cycles, and `we`/`re` issued meanwhile are ignored (`rvalid`=0). All locations afterwards read 0x00.
- Reset mid-clear: assert `rst` at `cnt`=10 → `busy` stays 1 and `rdata`=0 immediately. After release, `busy` lasts a full 32 cycles.
